// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 3-stage IF/DE/MW pipeline: memory
// wait stalls with timeout, branch/mret/trap redirects and DE operand forwarding.
module pipeline_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] mem_op_mw,
   input  logic       mem_ack,
   input  logic       br_taken_de,
   input  logic       mret_de,
   input  logic       irq_pending,
   input  logic [4:0] rs1_de,
   input  logic [4:0] rs2_de,
   input  logic [4:0] rd_mw,
   input  logic       rf_wr_mw,
   output logic       mem_req,
   output logic       stall_if,
   output logic       stall_de,
   output logic       flush_de,
   output logic       flush_mw,
   output logic [1:0] pc_sel,
   output logic       trap_take,
   output logic       mem_err,
   output logic       fwd_a,
   output logic       fwd_b
);

   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      MEM_WAIT    = 2'd1,
      TRAP_SETTLE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic       memPending;
   logic       pipeFree;
   logic       memReqRaw;
   logic       stallRaw;
   logic       flushDeRaw;
   logic       flushMwRaw;
   logic [1:0] pcSelRaw;
   logic       trapRaw;
   logic       memErrRaw;
   logic       fwdARaw;
   logic       fwdBRaw;

   assign memPending = |mem_op_mw;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pipeFree   = 1'b0;
      memReqRaw  = 1'b0;
      stallRaw   = 1'b0;
      flushDeRaw = 1'b0;
      flushMwRaw = 1'b0;
      pcSelRaw   = 2'd0;
      trapRaw    = 1'b0;
      memErrRaw  = 1'b0;

      case (state_q)
         MEM_WAIT: begin
            memReqRaw = 1'b1;
            // An ack in the timeout cycle still completes the access.
            if (mem_ack) begin
               pipeFree = 1'b1;
               state_d  = RUN;
               cnt_d    = '0;
            end else if (cnt_q >= TIMEOUT_VAL) begin
               stallRaw   = 1'b1;
               flushMwRaw = 1'b1;
               memErrRaw  = 1'b1;
               state_d    = RUN;
               cnt_d      = '0;
            end else begin
               stallRaw = 1'b1;
               cnt_d    = cnt_q + CNT_ONE;
            end
         end
         default: begin
            memReqRaw = memPending;
            state_d   = RUN;
            cnt_d     = '0;
            if (memPending && !mem_ack) begin
               stallRaw = 1'b1;
               state_d  = MEM_WAIT;
               cnt_d    = CNT_ONE;
            end else begin
               pipeFree = 1'b1;
            end
         end
      endcase

      // Interrupts are only accepted from RUN; TRAP_SETTLE masks them for a cycle.
      if (pipeFree) begin
         if (state_q == RUN && irq_pending) begin
            trapRaw    = 1'b1;
            pcSelRaw   = 2'd2;
            flushDeRaw = 1'b1;
            flushMwRaw = 1'b1;
            state_d    = TRAP_SETTLE;
         end else if (mret_de) begin
            pcSelRaw   = 2'd3;
            flushDeRaw = 1'b1;
         end else if (br_taken_de) begin
            pcSelRaw   = 2'd1;
            flushDeRaw = 1'b1;
         end
      end
   end

   assign fwdARaw = rf_wr_mw & (rd_mw != 5'd0) & (rd_mw == rs1_de);
   assign fwdBRaw = rf_wr_mw & (rd_mw != 5'd0) & (rd_mw == rs2_de);

   // Every output is forced low while reset is held, independent of state.
   assign mem_req   = rst & memReqRaw;
   assign stall_if  = rst & stallRaw;
   assign stall_de  = rst & stallRaw;
   assign flush_de  = rst & flushDeRaw;
   assign flush_mw  = rst & flushMwRaw;
   assign pc_sel    = rst ? pcSelRaw : 2'd0;
   assign trap_take = rst & trapRaw;
   assign mem_err   = rst & memErrRaw;
   assign fwd_a     = rst & fwdARaw;
   assign fwd_b     = rst & fwdBRaw;

endmodule
